// File: rtl/dmem_lsu_pkg.sv
// Shared constants and types for the dmem load/store unit.
// DMEM_LSU_MISALIGNED_SPLIT_EN adds the ACC1 state used by split accesses.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC0 = 3'd1,
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
        ST_ACC1 = 3'd2,
`endif
        ST_DATA = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_t;

    function automatic logic [3:0] base_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   base_mask = MASK_B;
            2'b01:   base_mask = MASK_H;
            default: base_mask = MASK_W;
        endcase
    endfunction

    // Stores have no unsigned variants, so funct3[2] is illegal for them.
    function automatic logic illegal_funct3(input logic [2:0] funct3, input logic we);
        illegal_funct3 = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                         (funct3 == 3'b111) || (we && funct3[2]);
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Load realignment: picks the addressed bytes out of one or two memory
// words and sign- or zero-extends them according to funct3.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] first_word,
    input  logic [31:0] second_word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [63:0] pair;
    logic [31:0] win;

    assign pair = {second_word, first_word};
    assign win  = 32'(pair >> {off, 3'b000});

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{win[7]}}, win[7:0]};
            F3_BU:   rdata = {24'b0, win[7:0]};
            F3_H:    rdata = {{16{win[15]}}, win[15:0]};
            F3_HU:   rdata = {16'b0, win[15:0]};
            F3_W:    rdata = win;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a byte-banked dmem with 1-cycle registered reads.
// Define DMEM_LSU_MISALIGNED_SPLIT_EN to split misaligned H/W accesses in two.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_we,
    input  logic [31:0]                i_req_addr,
    input  logic [2:0]                 i_req_funct3,
    input  logic [31:0]                i_req_wdata,
    output logic                       o_rsp_valid,
    output logic [31:0]                o_rsp_rdata,
    output logic                       o_rsp_err,
    output logic [DMEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic                       o_mem_read,
    output logic                       o_mem_write,
    output logic [3:0]                 o_mem_size,
    output logic [31:0]                o_mem_din,
    input  logic [31:0]                i_mem_dout
);

    localparam int WW = DMEM_ADDR_WIDTH - 2;

    lsu_state_t state, state_nxt;

    logic          req_we;
    logic [2:0]    req_funct3;
    logic [1:0]    req_off;
    logic [3:0]    req_strb_lo;
    logic [31:0]   req_din;
    logic [WW-1:0] req_word;

    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        accept;
    logic [1:0]  in_off;
    logic [7:0]  in_lanes;
    logic        in_err;
    logic [63:0] in_rot;
    logic        unused_addr_hi;

    logic        cmd_read;
    logic        cmd_write;
    logic [DMEM_ADDR_WIDTH-1:0] cmd_addr;
    logic [3:0]  cmd_size;
    logic [31:0] cmd_din;

    logic [31:0] load_first;
    logic [31:0] load_second;
    logic [31:0] load_data;

    assign o_req_ready    = (state == ST_IDLE) && i_rst_n;
    assign accept         = i_req_valid && o_req_ready;
    assign unused_addr_hi = ^i_req_addr[31:DMEM_ADDR_WIDTH];

    assign in_off   = i_req_addr[1:0];
    assign in_lanes = {4'b0000, base_mask(i_req_funct3)} << in_off;
    assign in_rot   = {i_req_wdata, i_req_wdata} << {in_off, 3'b000};

    // Any lane spilling into the next word is exactly the misaligned case.
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
    logic [3:0]    req_strb_hi;
    logic [31:0]   first_q;
    logic [WW-1:0] word_next;
    logic          has_hi;

    assign in_err    = illegal_funct3(i_req_funct3, i_req_we);
    assign word_next = req_word + WW'(1);
    assign has_hi    = |req_strb_hi;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            req_strb_hi <= '0;
            first_q     <= '0;
        end else begin
            if (accept) begin
                req_strb_hi <= in_lanes[7:4];
            end
            if (state == ST_ACC1) begin
                first_q <= i_mem_dout;
            end
        end
    end

    assign load_first  = has_hi ? first_q : i_mem_dout;
    assign load_second = has_hi ? i_mem_dout : 32'h0;
`else
    assign in_err      = illegal_funct3(i_req_funct3, i_req_we) || (|in_lanes[7:4]);
    assign load_first  = i_mem_dout;
    assign load_second = 32'h0;
`endif

    dmem_lsu_align u_align (
        .first_word  (load_first),
        .second_word (load_second),
        .off         (req_off),
        .funct3      (req_funct3),
        .rdata       (load_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_we      <= 1'b0;
            req_funct3  <= '0;
            req_off     <= '0;
            req_strb_lo <= '0;
            req_din     <= '0;
            req_word    <= '0;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= (state_nxt == ST_RESP);
            rsp_err_q   <= accept && in_err;
            rsp_rdata_q <= (state == ST_DATA) ? load_data : 32'h0;
            if (accept) begin
                req_we      <= i_req_we;
                req_funct3  <= i_req_funct3;
                req_off     <= in_off;
                req_strb_lo <= in_lanes[3:0];
                req_din     <= in_rot[63:32];
                req_word    <= i_req_addr[DMEM_ADDR_WIDTH-1:2];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_read  = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_din   = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = in_err ? ST_RESP : ST_ACC0;
                end
            end
            ST_ACC0: begin
                cmd_read  = !req_we;
                cmd_write = req_we;
                cmd_addr  = {req_word, 2'b00};
                cmd_size  = req_strb_lo;
                cmd_din   = req_we ? req_din : 32'h0;
                state_nxt = req_we ? ST_RESP : ST_DATA;
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
                if (has_hi) begin
                    state_nxt = ST_ACC1;
                end
`endif
            end
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
            ST_ACC1: begin
                cmd_read  = !req_we;
                cmd_write = req_we;
                cmd_addr  = {word_next, 2'b00};
                cmd_size  = req_strb_hi;
                cmd_din   = req_we ? req_din : 32'h0;
                state_nxt = req_we ? ST_RESP : ST_DATA;
            end
`endif
            ST_DATA: state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Gating on reset keeps a half-finished access from issuing another command.
    assign o_mem_read  = cmd_read && i_rst_n;
    assign o_mem_write = cmd_write && i_rst_n;
    assign o_mem_addr  = i_rst_n ? cmd_addr : '0;
    assign o_mem_size  = i_rst_n ? cmd_size : 4'b0000;
    assign o_mem_din   = i_rst_n ? cmd_din : 32'h0;

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a byte-banked memory model behind it.
// Expectations follow DMEM_LSU_MISALIGNED_SPLIT_EN when it is defined.
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_size;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    logic        rec_read  [1:6];
    logic        rec_write [1:6];
    logic [11:0] rec_addr  [1:6];
    logic [3:0]  rec_size  [1:6];
    logic [31:0] rec_din   [1:6];
    logic [31:0] rec_rdata [1:6];
    int          resp_k;
    int          n_rd;
    int          n_wr;
    logic [31:0] resp_data;
    logic        resp_err;

    dmem_lsu #(.DMEM_ADDR_WIDTH(12)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_addr   (req_addr),
        .i_req_funct3 (req_funct3),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_mem_addr   (mem_addr),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_mem_size   (mem_size),
        .o_mem_din    (mem_din),
        .i_mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read, dout held while read is low, per-byte writes.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem_dout <= 32'h0;
        end else begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_size[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
                end
            end
            if (mem_read) mem_dout <= mem[mem_addr[11:2]];
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and record six cycles of memory commands and responses.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr,
                                  input logic [2:0] f3, input logic [31:0] wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        #1 check_output("ready_at_issue", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b000;
        req_wdata  = 32'h0;
        resp_k     = 0;
        n_rd       = 0;
        n_wr       = 0;
        resp_data  = 32'h0;
        resp_err   = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rec_read[k]  = mem_read;
            rec_write[k] = mem_write;
            rec_addr[k]  = mem_addr;
            rec_size[k]  = mem_size;
            rec_din[k]   = mem_din;
            rec_rdata[k] = rsp_rdata;
            if (mem_read)  n_rd++;
            if (mem_write) n_wr++;
            if (rsp_valid && resp_k == 0) begin
                resp_k    = k;
                resp_data = rsp_rdata;
                resp_err  = rsp_err;
            end
        end
    endtask

    initial begin
        int   saw_valid;
        int   saw_cmd;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_funct3 = 3'b000;
        req_wdata  = 32'h0;

        repeat (2) @(negedge clk);
        check_output("reset_ready", 32'(req_ready), 32'h0);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("reset_mem_read", 32'(mem_read), 32'h0);
        check_output("reset_mem_write", 32'(mem_write), 32'h0);
        rst_n = 1'b1;

        // SW 0xDEADBEEF @0x010
        apply_stimulus(1'b1, 32'h010, 3'b010, 32'hDEADBEEF);
        check_output("sw_write", 32'(rec_write[1]), 32'h1);
        check_output("sw_addr", 32'(rec_addr[1]), 32'h010);
        check_output("sw_size", 32'(rec_size[1]), 32'hF);
        check_output("sw_din", rec_din[1], 32'hDEADBEEF);
        check_output("sw_resp_cycle", resp_k, 2);
        check_output("sw_resp_rdata", resp_data, 32'h0);

        // LW @0x010
        apply_stimulus(1'b0, 32'h010, 3'b010, 32'h0);
        check_output("lw_read", 32'(rec_read[1]), 32'h1);
        check_output("lw_addr", 32'(rec_addr[1]), 32'h010);
        check_output("lw_resp_cycle", resp_k, 3);
        check_output("lw_rdata", resp_data, 32'hDEADBEEF);
        check_output("lw_rdata_clears", rec_rdata[4], 32'h0);

        // SB to lane 3 of word 0x010
        apply_stimulus(1'b1, 32'h013, 3'b000, 32'hA5A5A5A5);
        check_output("sb_size", 32'(rec_size[1]), 32'h8);
        check_output("sb_din", rec_din[1], 32'hA5A5A5A5);
        check_output("sb_resp_cycle", resp_k, 2);

        apply_stimulus(1'b0, 32'h013, 3'b000, 32'h0);
        check_output("lb_rdata", resp_data, 32'hFFFFFFA5);
        apply_stimulus(1'b0, 32'h013, 3'b100, 32'h0);
        check_output("lbu_rdata", resp_data, 32'h000000A5);
        apply_stimulus(1'b0, 32'h010, 3'b010, 32'h0);
        check_output("lw_after_sb", resp_data, 32'hA5ADBEEF);

        // SH 0x8001 @0x022
        apply_stimulus(1'b1, 32'h022, 3'b001, 32'h00008001);
        check_output("sh_addr", 32'(rec_addr[1]), 32'h020);
        check_output("sh_size", 32'(rec_size[1]), 32'hC);
        check_output("sh_din", rec_din[1], 32'h80010000);
        apply_stimulus(1'b0, 32'h022, 3'b001, 32'h0);
        check_output("lh_rdata", resp_data, 32'hFFFF8001);
        apply_stimulus(1'b0, 32'h022, 3'b101, 32'h0);
        check_output("lhu_rdata", resp_data, 32'h00008001);

        // Misaligned SW/LW @0x031
        apply_stimulus(1'b1, 32'h031, 3'b010, 32'h11223344);
`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
        check_output("ssw_writes", n_wr, 2);
        check_output("ssw_addr0", 32'(rec_addr[1]), 32'h030);
        check_output("ssw_size0", 32'(rec_size[1]), 32'hE);
        check_output("ssw_din0", rec_din[1], 32'h22334411);
        check_output("ssw_addr1", 32'(rec_addr[2]), 32'h034);
        check_output("ssw_size1", 32'(rec_size[2]), 32'h1);
        check_output("ssw_resp_cycle", resp_k, 3);
        check_output("ssw_err", 32'(resp_err), 32'h0);
        apply_stimulus(1'b0, 32'h031, 3'b010, 32'h0);
        check_output("slw_reads", n_rd, 2);
        check_output("slw_addr1", 32'(rec_addr[2]), 32'h034);
        check_output("slw_resp_cycle", resp_k, 4);
        check_output("slw_rdata", resp_data, 32'h11223344);
`else
        check_output("msw_err", 32'(resp_err), 32'h1);
        check_output("msw_resp_cycle", resp_k, 1);
        check_output("msw_writes", n_wr, 0);
        check_output("msw_rdata", resp_data, 32'h0);
        apply_stimulus(1'b0, 32'h031, 3'b010, 32'h0);
        check_output("mlw_err", 32'(resp_err), 32'h1);
        check_output("mlw_resp_cycle", resp_k, 1);
        check_output("mlw_reads", n_rd, 0);
        apply_stimulus(1'b0, 32'h023, 3'b001, 32'h0);
        check_output("mlh_err", 32'(resp_err), 32'h1);
        check_output("mlh_reads", n_rd, 0);
`endif

        // Illegal funct3 load and unsigned store
        apply_stimulus(1'b0, 32'h010, 3'b011, 32'h0);
        check_output("f3_011_err", 32'(resp_err), 32'h1);
        check_output("f3_011_resp_cycle", resp_k, 1);
        check_output("f3_011_reads", n_rd, 0);
        apply_stimulus(1'b1, 32'h010, 3'b100, 32'h12345678);
        check_output("store_f3_100_err", 32'(resp_err), 32'h1);
        check_output("store_f3_100_writes", n_wr, 0);

`ifdef DMEM_LSU_MISALIGNED_SPLIT_EN
        // Split at the top word wraps the second half to word 0
        apply_stimulus(1'b1, 32'hFFD, 3'b010, 32'hCAFEF00D);
        check_output("wrap_sw_addr0", 32'(rec_addr[1]), 32'hFFC);
        check_output("wrap_sw_addr1", 32'(rec_addr[2]), 32'h000);
        apply_stimulus(1'b0, 32'hFFD, 3'b010, 32'h0);
        check_output("wrap_lw_addr1", 32'(rec_addr[2]), 32'h000);
        check_output("wrap_lw_rdata", resp_data, 32'hCAFEF00D);
`else
        apply_stimulus(1'b0, 32'hFFD, 3'b010, 32'h0);
        check_output("top_lw_err", 32'(resp_err), 32'h1);
        check_output("top_lw_reads", n_rd, 0);
`endif

        // Reset asserted during ACC0 of a load aborts it silently
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h010;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check_output("abort_acc0_read", 32'(mem_read), 32'h1);
        rst_n = 1'b0;
        #1 check_output("abort_read_gated", 32'(mem_read), 32'h0);
        @(negedge clk);
        check_output("abort_ready_low", 32'(req_ready), 32'h0);
        check_output("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        saw_valid = 0;
        saw_cmd   = 0;
        @(negedge clk);
        check_output("abort_ready_after", 32'(req_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) saw_valid++;
            if (mem_read || mem_write) saw_cmd++;
            @(negedge clk);
        end
        check_output("abort_no_rsp", saw_valid, 0);
        check_output("abort_no_cmd", saw_cmd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
